// File: rtl/max_tree_pkg.sv
// Shared configuration helpers for the max_tree_pipe compare tree: sizing
// derivations and the tie-break policy used by every compare node.
package max_tree_pkg;

  // Equal values resolve toward the lower entry index.
  localparam bit TIE_LOW_WINS = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 32'sd0;
    for (int v = 32'sd1; v < n; v = v * 32'sd2) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

  function automatic int tree_levels(input int num_entry);
    return clog2(num_entry);
  endfunction

  function automatic int tree_stages(input int levels, input int lvl_per_stg);
    return (levels + lvl_per_stg - 32'sd1) / lvl_per_stg;
  endfunction

  function automatic int idx_width(input int num_entry);
    return (clog2(num_entry) < 32'sd1) ? 32'sd1 : clog2(num_entry);
  endfunction

endpackage

// File: rtl/max_tree_node.sv
// One compare-select node of the max tree, purely combinational.
// The winner-index path exists only when MAX_TREE_IDX_EN is defined.
module max_tree_node
  import max_tree_pkg::*;
#(
  parameter int CNT_SIZE = 32
`ifdef MAX_TREE_IDX_EN
  ,
  parameter int IDX_W = 1
`endif
) (
  input  logic [CNT_SIZE-1:0] a_val_i,
  input  logic                a_act_i,
  input  logic [CNT_SIZE-1:0] b_val_i,
  input  logic                b_act_i,
`ifdef MAX_TREE_IDX_EN
  input  logic [IDX_W-1:0]    a_idx_i,
  input  logic [IDX_W-1:0]    b_idx_i,
  output logic [IDX_W-1:0]    y_idx_o,
`endif
  output logic [CNT_SIZE-1:0] y_val_o,
  output logic                y_act_o
);

  logic pick_b_s;
  logic act_s;

  // Operand b wins only when active and a is masked, smaller, or loses the tie policy.
  always_comb begin
    pick_b_s = 1'b0;
    act_s    = a_act_i | b_act_i;
    if (b_act_i && !a_act_i) begin
      pick_b_s = 1'b1;
    end else if (b_act_i && (b_val_i > a_val_i)) begin
      pick_b_s = 1'b1;
    end else if (b_act_i && !TIE_LOW_WINS && (b_val_i == a_val_i)) begin
      pick_b_s = 1'b1;
    end else begin
      pick_b_s = 1'b0;
    end
  end

  // Output mux; a node with no active operand reports a masked zero.
  always_comb begin
    y_act_o = act_s;
    y_val_o = '0;
`ifdef MAX_TREE_IDX_EN
    y_idx_o = '0;
`endif
    if (!act_s) begin
      y_val_o = '0;
    end else if (pick_b_s) begin
      y_val_o = b_val_i;
`ifdef MAX_TREE_IDX_EN
      y_idx_o = b_idx_i;
`endif
    end else begin
      y_val_o = a_val_i;
`ifdef MAX_TREE_IDX_EN
      y_idx_o = a_idx_i;
`endif
    end
  end

endmodule

// File: rtl/max_tree_pipe.sv
// Pipelined masked maximum over a flat counter table with per-stage valid/ready.
// Define MAX_TREE_IDX_EN to carry the winning entry index and expose max_idx.
module max_tree_pipe
  import max_tree_pkg::*;
#(
  parameter int NUM_ENTRY   = 64,
  parameter int CNT_SIZE    = 32,
  parameter int LVL_PER_STG = 2
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_ENTRY*CNT_SIZE-1:0] cnt_table,
  input  logic [NUM_ENTRY-1:0]          entry_mask,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CNT_SIZE-1:0]           max_cnt,
  output logic                          all_masked
`ifdef MAX_TREE_IDX_EN
  ,
  output logic [idx_width(NUM_ENTRY)-1:0] max_idx
`endif
);

  localparam int LEVELS = tree_levels(NUM_ENTRY);
  localparam int STAGES = tree_stages(LEVELS, LVL_PER_STG);
  localparam int NLEAF  = 32'sd1 << LEVELS;
`ifdef MAX_TREE_IDX_EN
  localparam int IDX_W  = idx_width(NUM_ENTRY);
`endif

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;
  logic [STAGES-1:0] vin_s;
  logic [STAGES-1:0] en_s;
  logic [STAGES:0]   adv_s;

  // Bubble-collapsing handshake: a stage loads when empty or when its successor drains.
  always_comb begin
    adv_s         = '0;
    vin_s         = '0;
    en_s          = '0;
    vld_d         = vld_q;
    adv_s[STAGES] = out_ready;
    for (int s = STAGES - 1; s >= 0; s--) begin
      adv_s[s] = ~vld_q[s] | adv_s[s+1];
    end
    vin_s[0] = in_valid;
    for (int s = 1; s < STAGES; s++) begin
      vin_s[s] = vld_q[s-1];
    end
    for (int s = 0; s < STAGES; s++) begin
      en_s[s] = adv_s[s] & vin_s[s];
      if (adv_s[s]) begin
        vld_d[s] = vin_s[s];
      end else begin
        vld_d[s] = vld_q[s];
      end
    end
  end

  // Stage valid bits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  // Level 0 holds the leaves; level l holds NLEAF>>l node results (registered at stage ends).
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int NN = NLEAF >> l;
    logic [CNT_SIZE-1:0] s_val [NN];
    logic                s_act [NN];
`ifdef MAX_TREE_IDX_EN
    logic [IDX_W-1:0]    s_idx [NN];
`endif
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < NN; i++) begin : g_ent
        if (i < NUM_ENTRY) begin : g_real
          assign s_val[i] = cnt_table[i*CNT_SIZE +: CNT_SIZE];
          assign s_act[i] = entry_mask[i];
        end else begin : g_pad
          assign s_val[i] = '0;
          assign s_act[i] = 1'b0;
        end
`ifdef MAX_TREE_IDX_EN
        assign s_idx[i] = IDX_W'(i);
`endif
      end
    end else begin : g_tree
      localparam int STG    = (l - 1) / LVL_PER_STG;
      localparam bit IS_REG = ((l % LVL_PER_STG) == 0) || (l == LEVELS);
      for (genvar j = 0; j < NN; j++) begin : g_node
        logic [CNT_SIZE-1:0] val_d;
        logic                act_d;
`ifdef MAX_TREE_IDX_EN
        logic [IDX_W-1:0]    idx_d;
`endif
        max_tree_node #(
          .CNT_SIZE(CNT_SIZE)
`ifdef MAX_TREE_IDX_EN
          ,
          .IDX_W(IDX_W)
`endif
        ) u_node (
          .a_val_i(g_lvl[l-1].s_val[2*j]),
          .a_act_i(g_lvl[l-1].s_act[2*j]),
          .b_val_i(g_lvl[l-1].s_val[2*j+1]),
          .b_act_i(g_lvl[l-1].s_act[2*j+1]),
`ifdef MAX_TREE_IDX_EN
          .a_idx_i(g_lvl[l-1].s_idx[2*j]),
          .b_idx_i(g_lvl[l-1].s_idx[2*j+1]),
          .y_idx_o(idx_d),
`endif
          .y_val_o(val_d),
          .y_act_o(act_d)
        );
        if (IS_REG) begin : g_reg
          logic [CNT_SIZE-1:0] val_q;
          logic                act_q;
`ifdef MAX_TREE_IDX_EN
          logic [IDX_W-1:0]    idx_q;
`endif
          // Stage boundary register, loaded only when the stage accepts a valid vector.
          always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
              val_q <= '0;
              act_q <= 1'b0;
`ifdef MAX_TREE_IDX_EN
              idx_q <= '0;
`endif
            end else if (en_s[STG]) begin
              val_q <= val_d;
              act_q <= act_d;
`ifdef MAX_TREE_IDX_EN
              idx_q <= idx_d;
`endif
            end else begin
              val_q <= val_q;
              act_q <= act_q;
`ifdef MAX_TREE_IDX_EN
              idx_q <= idx_q;
`endif
            end
          end
          assign s_val[j] = val_q;
          assign s_act[j] = act_q;
`ifdef MAX_TREE_IDX_EN
          assign s_idx[j] = idx_q;
`endif
        end else begin : g_comb
          assign s_val[j] = val_d;
          assign s_act[j] = act_d;
`ifdef MAX_TREE_IDX_EN
          assign s_idx[j] = idx_d;
`endif
        end
      end
    end
  end

  assign in_ready   = adv_s[0];
  assign out_valid  = vld_q[STAGES-1];
  assign max_cnt    = g_lvl[LEVELS].s_val[0];
  assign all_masked = vld_q[STAGES-1] & ~g_lvl[LEVELS].s_act[0];
`ifdef MAX_TREE_IDX_EN
  assign max_idx    = g_lvl[LEVELS].s_idx[0];
`endif

endmodule

// File: tb/tb_max_tree_pipe.sv
// Randomized and directed bench for max_tree_pipe: a 64-entry default instance and a
// 37-entry single-level-per-stage instance, checked against a plain-loop reference model.
`timescale 1ns/1ps
module tb_max_tree_pipe;

  localparam int NA = 64;
  localparam int NB = 37;
  localparam int CW = 32;
  localparam int SA = 3;
  localparam int SB = 6;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic             sel;
  logic             t_in_valid;
  logic             t_out_ready;
  logic [NA*CW-1:0] t_cnt;
  logic [NA-1:0]    t_mask;

  logic a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_all;
  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_all;
  logic [CW-1:0] a_max, b_max, m_max;
  logic m_in_ready, m_out_valid, m_all;
`ifdef MAX_TREE_IDX_EN
  logic [5:0] a_idx, b_idx, m_idx;
`endif

  assign a_in_valid  = t_in_valid & ~sel;
  assign b_in_valid  = t_in_valid & sel;
  assign a_out_ready = sel ? 1'b1 : t_out_ready;
  assign b_out_ready = sel ? t_out_ready : 1'b1;
  assign m_in_ready  = sel ? b_in_ready : a_in_ready;
  assign m_out_valid = sel ? b_out_valid : a_out_valid;
  assign m_max       = sel ? b_max : a_max;
  assign m_all       = sel ? b_all : a_all;
`ifdef MAX_TREE_IDX_EN
  assign m_idx       = sel ? b_idx : a_idx;
`endif

  max_tree_pipe #(.NUM_ENTRY(NA), .CNT_SIZE(CW), .LVL_PER_STG(2)) u_dut_a (
    .clk(clk), .rstn(rstn), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .cnt_table(t_cnt), .entry_mask(t_mask), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .max_cnt(a_max), .all_masked(a_all)
`ifdef MAX_TREE_IDX_EN
    , .max_idx(a_idx)
`endif
  );

  max_tree_pipe #(.NUM_ENTRY(NB), .CNT_SIZE(CW), .LVL_PER_STG(1)) u_dut_b (
    .clk(clk), .rstn(rstn), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .cnt_table(t_cnt[NB*CW-1:0]), .entry_mask(t_mask[NB-1:0]), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .max_cnt(b_max), .all_masked(b_all)
`ifdef MAX_TREE_IDX_EN
    , .max_idx(b_idx)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [CW-1:0] mv [NA];
  bit            mm [NA];

  typedef struct packed {
    logic [CW-1:0] cnt;
    logic [31:0]   idx;
    logic          all;
  } exp_t;

  function automatic int n_ent();
    return sel ? NB : NA;
  endfunction

  function automatic int stages();
    return sel ? SB : SA;
  endfunction

  // Maximum over participating entries; strict > keeps the lowest index on ties.
  function automatic exp_t ref_model(input int n);
    exp_t e;
    e.cnt = '0;
    e.idx = '0;
    e.all = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (mm[i] && (e.all || (mv[i] > e.cnt))) begin
        e.cnt = mv[i];
        e.idx = 32'(i);
        e.all = 1'b0;
      end
    end
    return e;
  endfunction

  task automatic check_result(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check_result({tag, "_max"}, 64'(m_max), 64'(e.cnt));
    check_result({tag, "_all"}, 64'(m_all), 64'(e.all));
`ifdef MAX_TREE_IDX_EN
    if (!e.all) check_result({tag, "_idx"}, 64'(m_idx), 64'(e.idx));
`endif
  endtask

  task automatic load_inputs();
    for (int i = 0; i < NA; i++) begin
      t_cnt[i*CW +: CW] = mv[i];
      t_mask[i]         = mm[i];
    end
  endtask

  task automatic junk_inputs();
    for (int i = 0; i < NA; i++) begin
      t_cnt[i*CW +: CW] = $urandom;
      t_mask[i]         = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic rand_vec(input bit wide);
    int mode;
    mode = $urandom_range(0, 7);
    for (int i = 0; i < NA; i++) begin
      mv[i] = wide ? CW'($urandom) : CW'($urandom_range(0, 7));
      mm[i] = (mode == 0) ? 1'b0 : ((mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0));
    end
  endtask

  task automatic run_single(input string tag);
    exp_t e;
    int   lat;
    bit   seen;
    e = ref_model(n_ent());
    load_inputs();
    t_in_valid  = 1'b1;
    t_out_ready = 1'b1;
    @(negedge clk);
    check_result({tag, "_accept"}, 64'(m_in_ready), 64'd1);
    @(posedge clk); #1;
    t_in_valid = 1'b0;
    junk_inputs();
    lat  = 1;
    seen = 1'b0;
    while (!seen && (lat <= 20)) begin
      @(negedge clk);
      if (m_out_valid) begin
        seen = 1'b1;
      end else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    check_result({tag, "_seen"}, 64'(seen), 64'd1);
    check_result({tag, "_latency"}, 64'(lat), 64'(stages()));
    check_outputs(tag, e);
    @(posedge clk); #1;
  endtask

  task automatic run_stream(input string tag, input int nvec, input bit rnd);
    exp_t          q[$];
    exp_t          e;
    int            sent, got, cyc;
    bit            acc, hold_v, exp_rdy;
    logic [CW-1:0] h_cnt;
    logic          h_all;
    logic [5:0]    h_idx;
    bit            pat[4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    sent = 0; got = 0; cyc = 0; hold_v = 1'b0; h_cnt = '0; h_all = 1'b0; h_idx = '0;
    rand_vec(1'($urandom_range(0, 1)));
    load_inputs();
    t_in_valid  = 1'b1;
    t_out_ready = 1'b1;
    while ((got < nvec) && (cyc < 4000)) begin
      @(negedge clk);
      exp_rdy = !((q.size() == stages()) && !t_out_ready);
      check_result({tag, "_in_ready"}, 64'(m_in_ready), 64'(exp_rdy));
      if (hold_v) begin
        check_result({tag, "_hold_valid"}, 64'(m_out_valid), 64'd1);
        check_result({tag, "_hold_max"}, 64'(m_max), 64'(h_cnt));
        check_result({tag, "_hold_all"}, 64'(m_all), 64'(h_all));
`ifdef MAX_TREE_IDX_EN
        check_result({tag, "_hold_idx"}, 64'(m_idx), 64'(h_idx));
        h_idx = m_idx;
`endif
      end
      hold_v = m_out_valid && !t_out_ready;
      h_cnt  = m_max;
      h_all  = m_all;
`ifdef MAX_TREE_IDX_EN
      h_idx  = m_idx;
`endif
      if (m_out_valid && t_out_ready) begin
        if (q.size() == 0) begin
          check_result({tag, "_spurious"}, 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          check_outputs(tag, e);
          got++;
        end
      end
      acc = t_in_valid && m_in_ready;
      if (acc) begin
        q.push_back(ref_model(n_ent()));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) rand_vec(1'($urandom_range(0, 1)));
      t_in_valid  = (sent < nvec) && (!rnd || ($urandom_range(0, 3) != 0));
      t_out_ready = rnd ? ($urandom_range(0, 2) != 0) : pat[cyc % 4];
      if (t_in_valid) load_inputs();
      else junk_inputs();
    end
    check_result({tag, "_count"}, 64'(got), 64'(nvec));
    check_result({tag, "_left"}, 64'(q.size()), 64'd0);
    t_in_valid  = 1'b0;
    t_out_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit spur;
    sel = 1'b0; rstn = 1'b0; t_in_valid = 1'b0; t_out_ready = 1'b1;
    t_cnt = '0; t_mask = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_result("rst_a_valid", 64'(a_out_valid), 64'd0);
    check_result("rst_a_max", 64'(a_max), 64'd0);
    check_result("rst_a_all", 64'(a_all), 64'd0);
    check_result("rst_b_valid", 64'(b_out_valid), 64'd0);
    check_result("rst_b_max", 64'(b_max), 64'd0);
`ifdef MAX_TREE_IDX_EN
    check_result("rst_a_idx", 64'(a_idx), 64'd0);
`endif
    rstn = 1'b1;
    @(negedge clk);
    check_result("rst_in_ready", 64'(a_in_ready), 64'd1);
    @(posedge clk); #1;

    for (int i = 0; i < NA; i++) begin mv[i] = CW'(i); mm[i] = 1'b1; end
    mv[50] = 32'hFFFF_FFFF;
    run_single("top50");

    for (int i = 0; i < NA; i++) begin mv[i] = 32'h10; mm[i] = 1'b1; end
    mv[7] = 32'h100; mv[40] = 32'h100; mv[63] = 32'h100;
    run_single("tie");

    for (int i = 0; i < NA; i++) begin mv[i] = 32'h1; mm[i] = 1'b1; end
    mv[5] = 32'h900; mm[5] = 1'b0; mv[9] = 32'h800;
    run_single("mask");

    for (int i = 0; i < NA; i++) mm[i] = 1'b0;
    run_single("all_masked");

    run_stream("bp", 10, 1'b0);
    run_stream("rnd_a", 40, 1'b1);

    rand_vec(1'b1);
    load_inputs();
    t_in_valid  = 1'b1;
    t_out_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    t_in_valid = 1'b0;
    rstn = 1'b0;
    #2;
    check_result("rst_mid_valid", 64'(a_out_valid), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    spur = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (a_out_valid) spur = 1'b1;
      @(posedge clk); #1;
    end
    check_result("rst_mid_flush", 64'(spur), 64'd0);
    check_result("rst_mid_ready", 64'(a_in_ready), 64'd1);
    for (int i = 0; i < NA; i++) begin mv[i] = CW'($urandom_range(0, 255)); mm[i] = 1'b1; end
    run_single("rst_after");

    sel = 1'b1;
    for (int i = 0; i < NA; i++) begin mv[i] = CW'($urandom_range(0, 2)); mm[i] = 1'b1; end
    mv[36] = 32'h3;
    run_single("b_edge");
    for (int i = 0; i < NA; i++) begin mv[i] = '0; mm[i] = 1'b1; end
    run_single("b_zero");
    for (int i = 0; i < NA; i++) mm[i] = 1'b0;
    mm[36] = 1'b1;
    run_single("b_last_only");
    for (int i = 0; i < NA; i++) mm[i] = 1'b0;
    run_single("b_all_masked");
    run_stream("rnd_b", 30, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
